// File: rtl/sqrt_pkg.sv
// Shared helpers for the pipelined square root: iteration count, latency
// from the register mask, and the default all-ones mask.
package sqrt_pkg;

  function automatic int calc_iter(input int datawidth, input int frac_bits);
    return (datawidth + 1) / 2 + frac_bits;
  endfunction

  function automatic int popcount(input logic [63:0] mask);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (mask[i]) n++;
    end
    return n;
  endfunction

  function automatic logic [63:0] mask_all(input int nbits);
    return (64'd1 << nbits) - 64'd1;
  endfunction

endpackage

// File: rtl/sqrt_pipe_iter.sv
// One restoring square-root iteration: bring in the next radicand bit-pair,
// trial-subtract {q, 01}, keep the difference if it did not go negative.
module sqrt_pipe_iter #(
  parameter int RW = 4,
  parameter int XW = 8
) (
  input  logic [RW+1:0] ac_in,
  input  logic [XW-1:0] x_in,
  input  logic [RW-1:0] q_in,
  output logic [RW+1:0] ac_out,
  output logic [XW-1:0] x_out,
  output logic [RW-1:0] q_out
);

  localparam int REMW = RW + 1;

  logic [REMW:0] a;
  logic [REMW:0] d;
  logic          ge;
  logic          unused_bits;

  // The incoming remainder never exceeds 2*q < 2^RW, so its two MSBs are zero.
  assign a  = {ac_in[REMW-2:0], x_in[XW-1 -: 2]};
  assign d  = {q_in, 2'b01};
  assign ge = (a >= d);

  assign ac_out = ge ? (a - d) : a;
  assign x_out  = x_in << 2;

  always_comb begin
    q_out    = q_in << 1;
    q_out[0] = ge;
  end

  assign unused_bits = ^{ac_in[REMW:REMW-1], q_in[RW-1]};

endmodule

// File: rtl/sqrt_pipe.sv
// Pipelined restoring square root with valid/ready flow control and a tag
// sideband; PIPE_MASK picks which stage boundaries are registered.
module sqrt_pipe
  import sqrt_pkg::*;
#(
  parameter int          DATAWIDTH = 8,
  parameter int          FRAC_BITS = 0,
  parameter int          TAG_W     = 4,
  parameter logic [63:0] PIPE_MASK = mask_all(calc_iter(DATAWIDTH, FRAC_BITS) + 1),
  localparam int         ITER      = calc_iter(DATAWIDTH, FRAC_BITS),
  localparam int         RW        = ITER,
  localparam int         REMW      = RW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [DATAWIDTH-1:0] i_rad,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [RW-1:0]    o_root,
  output logic [REMW-1:0]  o_rem,
  output logic [TAG_W-1:0] o_tag
);

  localparam int XW  = 2 * ITER;
  localparam int LAT = popcount(PIPE_MASK & mask_all(ITER + 1));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XW-1:0]    x;
    logic [RW-1:0]    q;
    logic [REMW:0]    ac;
  } stage_t;

  stage_t [ITER:0] pipe;
  stage_t          st_in;
  stage_t          last;
  logic [XW-1:0]   rad_ext;
  logic            adv;
  logic            unused_out;

  // Odd widths gain a zero MSB; fractional bits append zero pairs below.
  always_comb begin
    rad_ext                  = '0;
    rad_ext[DATAWIDTH-1:0]   = i_rad;
    st_in.valid              = i_valid;
    st_in.tag                = i_tag;
    st_in.x                  = rad_ext << (2 * FRAC_BITS);
    st_in.q                  = '0;
    st_in.ac                 = '0;
  end

  for (genvar k = 0; k <= ITER; k++) begin : g_st
    stage_t d;
    stage_t cur;

    if (k == 0) begin : g_src
      assign d = st_in;
    end else begin : g_iter
      stage_t          p;
      logic [REMW:0]   ac_nx;
      logic [XW-1:0]   x_nx;
      logic [RW-1:0]   q_nx;

      assign p = pipe[k-1];

      sqrt_pipe_iter #(
        .RW(RW),
        .XW(XW)
      ) u_iter (
        .ac_in (p.ac),
        .x_in  (p.x),
        .q_in  (p.q),
        .ac_out(ac_nx),
        .x_out (x_nx),
        .q_out (q_nx)
      );

      assign d = '{valid: p.valid, tag: p.tag, x: x_nx, q: q_nx, ac: ac_nx};
    end

    if (PIPE_MASK[k]) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          cur <= '0;
        end else if (adv) begin
          cur <= d;
        end
      end
    end else begin : g_wire
      assign cur = d;
    end

    assign pipe[k] = cur;
  end

  assign last    = pipe[ITER];
  assign o_valid = last.valid;
  assign o_root  = last.q;
  assign o_rem   = last.ac[REMW-1:0];
  assign o_tag   = last.tag;

  // Global stall: every register advances together only when the output slot frees.
  assign adv     = o_ready | ~o_valid;
  assign i_ready = (LAT == 0) ? o_ready : (adv | rst);

  assign unused_out = ^{last.x, last.ac[REMW]};

endmodule

// File: tb/tb_sqrt_pipe.sv
// Self-checking bench for sqrt_pipe: directed vectors across several
// parameter sets, backpressured streams, and reset while requests are in flight.
module tb_sqrt_pipe;

  logic       clk;
  logic       rst;
  logic       iv_b;
  logic       ordy;
  logic [8:0] rad_b;
  logic [3:0] tag_b;
  int         cur;

  int total;
  int bad;

  logic       ir0, ov0, ir1, ov1, ir2, ov2, ir3, ov3, ir4, ov4, ir5, ov5;
  logic [3:0] root0, root3, root4, root5;
  logic [4:0] rem0, rem3, rem4, rem5;
  logic [4:0] root1;
  logic [5:0] rem1;
  logic [7:0] root2;
  logic [8:0] rem2;
  logic [3:0] tag0, tag1, tag2, tag3, tag4, tag5;

  logic        ir_s, ov_s;
  logic [15:0] root_s, rem_s;
  logic [3:0]  tag_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sqrt_pipe #(.DATAWIDTH(8)) u0 (
    .clk(clk), .rst(rst), .i_valid(iv_b && cur == 0), .i_ready(ir0), .i_rad(rad_b[7:0]),
    .i_tag(tag_b), .o_valid(ov0), .o_ready(ordy), .o_root(root0), .o_rem(rem0), .o_tag(tag0));

  sqrt_pipe #(.DATAWIDTH(9)) u1 (
    .clk(clk), .rst(rst), .i_valid(iv_b && cur == 1), .i_ready(ir1), .i_rad(rad_b),
    .i_tag(tag_b), .o_valid(ov1), .o_ready(ordy), .o_root(root1), .o_rem(rem1), .o_tag(tag1));

  sqrt_pipe #(.DATAWIDTH(8), .FRAC_BITS(4)) u2 (
    .clk(clk), .rst(rst), .i_valid(iv_b && cur == 2), .i_ready(ir2), .i_rad(rad_b[7:0]),
    .i_tag(tag_b), .o_valid(ov2), .o_ready(ordy), .o_root(root2), .o_rem(rem2), .o_tag(tag2));

  sqrt_pipe #(.DATAWIDTH(8), .PIPE_MASK(64'd0)) u3 (
    .clk(clk), .rst(rst), .i_valid(iv_b && cur == 3), .i_ready(ir3), .i_rad(rad_b[7:0]),
    .i_tag(tag_b), .o_valid(ov3), .o_ready(ordy), .o_root(root3), .o_rem(rem3), .o_tag(tag3));

  sqrt_pipe #(.DATAWIDTH(8), .PIPE_MASK(64'b00001)) u4 (
    .clk(clk), .rst(rst), .i_valid(iv_b && cur == 4), .i_ready(ir4), .i_rad(rad_b[7:0]),
    .i_tag(tag_b), .o_valid(ov4), .o_ready(ordy), .o_root(root4), .o_rem(rem4), .o_tag(tag4));

  sqrt_pipe #(.DATAWIDTH(8), .PIPE_MASK(64'b10100)) u5 (
    .clk(clk), .rst(rst), .i_valid(iv_b && cur == 5), .i_ready(ir5), .i_rad(rad_b[7:0]),
    .i_tag(tag_b), .o_valid(ov5), .o_ready(ordy), .o_root(root5), .o_rem(rem5), .o_tag(tag5));

  always_comb begin
    ir_s   = 1'b0;
    ov_s   = 1'b0;
    root_s = '0;
    rem_s  = '0;
    tag_s  = '0;
    case (cur)
      0: begin ir_s = ir0; ov_s = ov0; root_s = 16'(root0); rem_s = 16'(rem0); tag_s = tag0; end
      1: begin ir_s = ir1; ov_s = ov1; root_s = 16'(root1); rem_s = 16'(rem1); tag_s = tag1; end
      2: begin ir_s = ir2; ov_s = ov2; root_s = 16'(root2); rem_s = 16'(rem2); tag_s = tag2; end
      3: begin ir_s = ir3; ov_s = ov3; root_s = 16'(root3); rem_s = 16'(rem3); tag_s = tag3; end
      4: begin ir_s = ir4; ov_s = ov4; root_s = 16'(root4); rem_s = 16'(rem4); tag_s = tag4; end
      5: begin ir_s = ir5; ov_s = ov5; root_s = 16'(root5); rem_s = 16'(rem5); tag_s = tag5; end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Single request with o_ready held high; returns cycles until o_valid and the result.
  task automatic single(input int idx, input int rad, input int tag, output int lat,
                        output int r, output int m, output int t);
    @(negedge clk);
    cur   = idx;
    ordy  = 1'b1;
    rad_b = 9'(rad);
    tag_b = 4'(tag);
    iv_b  = 1'b1;
    #1;
    lat = 0;
    while (!ov_s && lat < 20) begin
      @(posedge clk);
      #1;
      iv_b = 1'b0;
      lat++;
    end
    r = int'(root_s);
    m = int'(rem_s);
    t = int'(tag_s);
    iv_b = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Back-to-back stream of 0..255 under a random 50% o_ready pattern.
  task automatic stream(input int idx);
    int in_cnt, out_cnt, cyc, both;
    logic held;
    logic [15:0] h_root, h_rem;
    logic [3:0] h_tag;
    int er;
    in_cnt = 0; out_cnt = 0; cyc = 0; both = 0; held = 1'b0;
    h_root = '0; h_rem = '0; h_tag = '0;
    @(negedge clk);
    cur = idx;
    while (out_cnt < 256 && cyc < 3000) begin
      ordy  = 1'($urandom_range(0, 1));
      iv_b  = (in_cnt < 256);
      rad_b = 9'(in_cnt);
      tag_b = 4'(in_cnt);
      #1;
      if (held) begin
        chk("hold_valid", 64'(ov_s), 64'd1);
        chk("hold_data", {h_root, h_rem, h_tag}, {root_s, rem_s, tag_s});
      end
      held   = ov_s & ~ordy;
      h_root = root_s;
      h_rem  = rem_s;
      h_tag  = tag_s;
      if (iv_b && ir_s && ov_s && ordy) both++;
      if (ov_s && ordy) begin
        er = isqrt(out_cnt);
        chk("stream_root", 64'(root_s), 64'(er));
        chk("stream_rem", 64'(rem_s), 64'(out_cnt - er * er));
        chk("stream_tag", 64'(tag_s), 64'(out_cnt % 16));
        out_cnt++;
      end
      if (iv_b && ir_s) in_cnt++;
      @(negedge clk);
      cyc++;
    end
    chk("stream_count", 64'(out_cnt), 64'd256);
    chk("stream_overlap", 64'(both > 0), 64'd1);
    iv_b = 1'b0;
    ordy = 1'b1;
    repeat (12) @(negedge clk);
    chk("stream_drained", 64'(ov_s), 64'd0);
  endtask

  typedef struct {
    int idx;
    int rad;
    int tag;
    int lat;
    int root;
    int rem;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, r, m, t, stale;
    total = 0;
    bad   = 0;

    vecs[0]  = '{0, 200,  3, 5, 14,  4};
    vecs[1]  = '{0,   0,  1, 5,  0,  0};
    vecs[2]  = '{0, 255,  2, 5, 15, 30};
    vecs[3]  = '{1, 511,  4, 6, 22, 27};
    vecs[4]  = '{1, 256,  5, 6, 16,  0};
    vecs[5]  = '{2,   2,  6, 9, 22, 28};
    vecs[6]  = '{2,   1,  7, 9, 16,  0};
    vecs[7]  = '{3, 200,  8, 0, 14,  4};
    vecs[8]  = '{4, 200,  9, 1, 14,  4};
    vecs[9]  = '{5, 200, 10, 2, 14,  4};
    vecs[10] = '{5, 255, 11, 2, 15, 30};
    vecs[11] = '{3, 255, 12, 0, 15, 30};

    cur   = 0;
    rst   = 1'b1;
    iv_b  = 1'b0;
    ordy  = 1'b1;
    rad_b = '0;
    tag_b = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_ready", 64'(ir0), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_valid", 64'({ov0, ov1, ov2, ov4, ov5}), 64'd0);
    chk("reset_data", {root0, rem0, tag0}, 64'd0);
    chk("reset_ready_after", 64'(ir0), 64'd1);

    for (int i = 0; i < 12; i++) begin
      single(vecs[i].idx, vecs[i].rad, vecs[i].tag, lat, r, m, t);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_root", i), 64'(r), 64'(vecs[i].root));
      chk($sformatf("vec%0d_rem", i), 64'(m), 64'(vecs[i].rem));
      chk($sformatf("vec%0d_tag", i), 64'(t), 64'(vecs[i].tag));
    end

    stream(0);
    stream(3);
    stream(4);
    stream(5);

    // Reset with three requests in flight on the full-mask instance.
    @(negedge clk);
    cur  = 0;
    ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv_b  = 1'b1;
      rad_b = 9'(100 + i);
      tag_b = 4'(5 + i);
      @(negedge clk);
    end
    iv_b = 1'b0;
    rst  = 1'b1;
    #1;
    chk("midrst_ready", 64'(ir0), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 64'(ov0), 64'd0);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (ov0) stale++;
    end
    chk("midrst_no_stale", 64'(stale), 64'd0);
    single(0, 49, 9, lat, r, m, t);
    chk("midrst_lat", 64'(lat), 64'd5);
    chk("midrst_root", 64'(r), 64'd7);
    chk("midrst_rem", 64'(m), 64'd0);
    chk("midrst_tag", 64'(t), 64'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
